path_metric_argmin: RTL and testbench

Parametrised best-state selector for the Viterbi decoder. Each cycle it accepts one vector of per-state accumulated path metrics and survivor paths. A pipelined pairwise min tree finds the lowest-metric state and emits that state's survivor path, its index and its metric. It sits between the add-compare-select array and the output/traceback stage, and adds three things: ready/valid backpressure, a metric-normalisation request, and frame-boundary marking.

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/argmin_level.sv | 84 ++++++++
 rtl/path_metric_argmin.sv | 139 +++++++++++++
 tb/tb_path_metric_argmin.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared helpers for the Viterbi best-state selector.
//   clog2         : ceiling log2 for sizing index and counter fields
//   TIE_LOW_INDEX : equal metrics resolve to the left (lower-index) candidate
// The candidate tuple {metric, state index, path} depends on the widths chosen
// by the instantiating block, so each tree level declares it from its own
// parameters (cand_t in argmin_level).
// -----------------------------------------------------------------------------
package viterbi_pkg;

   localparam bit TIE_LOW_INDEX = 1'b1;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/argmin_level.sv
// -----------------------------------------------------------------------------
// argmin_level
// One level of the pipelined min tree. Candidates 2j and 2j+1 are compared
// and the smaller one is registered into output slot j.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en                    pipeline advance (global stall when low)
//   valid_in / valid_out  level valid bit in / registered valid bit out
//   metric_in, idx_in, path_in     N_IN packed candidates
//   metric_out, idx_out, path_out  N_IN/2 registered winners
// -----------------------------------------------------------------------------
module argmin_level
   import viterbi_pkg::*;
#(
   parameter int N_IN     = 2,
   parameter int METRIC_W = 4,
   parameter int IDX_W    = 1,
   parameter int PATH_W   = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           valid_in,
   input  logic [N_IN*METRIC_W-1:0]       metric_in,
   input  logic [N_IN*IDX_W-1:0]          idx_in,
   input  logic [N_IN*PATH_W-1:0]         path_in,
   output logic                           valid_out,
   output logic [(N_IN/2)*METRIC_W-1:0]   metric_out,
   output logic [(N_IN/2)*IDX_W-1:0]      idx_out,
   output logic [(N_IN/2)*PATH_W-1:0]     path_out
);

   localparam int N_OUT = N_IN / 2;

   typedef struct packed {
      logic [METRIC_W-1:0] metric;
      logic [IDX_W-1:0]    idx;
      logic [PATH_W-1:0]   path;
   } cand_t;

   cand_t win [N_OUT];

   // The left candidate of each pair always carries the lower state index,
   // so letting it win on equality yields the lowest-indexed minimum overall.
   always_comb begin
      cand_t a;
      cand_t b;
      a = '0;
      b = '0;
      for (int j = 0; j < N_OUT; j++) begin
         a.metric = metric_in[(2*j)*METRIC_W +: METRIC_W];
         a.idx    = idx_in[(2*j)*IDX_W +: IDX_W];
         a.path   = path_in[(2*j)*PATH_W +: PATH_W];
         b.metric = metric_in[(2*j+1)*METRIC_W +: METRIC_W];
         b.idx    = idx_in[(2*j+1)*IDX_W +: IDX_W];
         b.path   = path_in[(2*j+1)*PATH_W +: PATH_W];
         if ((a.metric < b.metric) || (TIE_LOW_INDEX && (a.metric == b.metric)))
            win[j] = a;
         else
            win[j] = b;
      end
   end

   // Data only loads behind a valid bit, so bubbles leave the last result
   // in place; the valid bit itself advances on every enabled cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_out  <= 1'b0;
         metric_out <= '0;
         idx_out    <= '0;
         path_out   <= '0;
      end else if (en) begin
         valid_out <= valid_in;
         if (valid_in) begin
            for (int j = 0; j < N_OUT; j++) begin
               metric_out[j*METRIC_W +: METRIC_W] <= win[j].metric;
               idx_out[j*IDX_W +: IDX_W]          <= win[j].idx;
               path_out[j*PATH_W +: PATH_W]       <= win[j].path;
            end
         end
      end
   end

endmodule

// File: rtl/path_metric_argmin.sv
// -----------------------------------------------------------------------------
// path_metric_argmin
// Best-state selector: picks the lowest-metric state (lowest index on ties)
// from one vector of path metrics per cycle and emits its survivor path.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     input handshake for metric_in/path_in
//   metric_in               state s at [s*METRIC_W +: METRIC_W]
//   path_in                 state s at [s*PATH_W +: PATH_W]
//   out_valid / out_ready   output handshake
//   out_path, out_state, out_metric  winning path, index and metric
//   norm_req                out_metric >= NORM_THRESH (qualified by out_valid)
//   frame_end               last beat of a FRAME_LEN-beat frame
//   renew                   toggles on every output transfer
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn by this block until it is accepted,
// and in_ready depends only on the output side (never on in_valid).
// -----------------------------------------------------------------------------
module path_metric_argmin
   import viterbi_pkg::*;
#(
   parameter int NUM_STATES  = 4,
   parameter int METRIC_W    = 4,
   parameter int PATH_W      = 8,
   parameter int NORM_THRESH = 2**(METRIC_W-1),
   parameter int FRAME_LEN   = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_STATES*METRIC_W-1:0] metric_in,
   input  logic [NUM_STATES*PATH_W-1:0]   path_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [PATH_W-1:0]              out_path,
   output logic [clog2(NUM_STATES)-1:0]   out_state,
   output logic [METRIC_W-1:0]            out_metric,
   output logic                           norm_req,
   output logic                           frame_end,
   output logic                           renew
);

   localparam int L     = clog2(NUM_STATES);
   localparam int CNT_W = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
   // Threshold clamped to one bit above the metric range so it never wraps.
   localparam int THRESH_C = (NORM_THRESH > 2**METRIC_W) ? 2**METRIC_W : NORM_THRESH;
   localparam logic [METRIC_W:0] THRESH_X = (METRIC_W+1)'(THRESH_C);

   logic [L:0]                   vld;
   logic [NUM_STATES*L-1:0]      idx0;
   logic                         xfer;
   logic [CNT_W-1:0]             beat_cnt;
   logic [CNT_W-1:0]             beat_next;

   // Global stall; held high during reset so upstream never blocks on us.
   assign in_ready = !rst_n || !out_valid || out_ready;
   assign xfer     = out_valid && out_ready;
   assign vld[0]   = in_valid;

   always_comb begin
      idx0 = '0;
      for (int s = 0; s < NUM_STATES; s++)
         idx0[s*L +: L] = L'(s);
   end

   // The last level's registers double as the output register, which gives
   // L cycles from input transfer to out_valid.
   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int NI = NUM_STATES >> k;
      localparam int NO = NI / 2;
      logic [NI*METRIC_W-1:0] m_d;
      logic [NI*L-1:0]        i_d;
      logic [NI*PATH_W-1:0]   p_d;
      logic [NO*METRIC_W-1:0] m_q;
      logic [NO*L-1:0]        i_q;
      logic [NO*PATH_W-1:0]   p_q;

      if (k == 0) begin : g_first
         assign m_d = metric_in;
         assign i_d = idx0;
         assign p_d = path_in;
      end else begin : g_next
         assign m_d = g_lvl[k-1].m_q;
         assign i_d = g_lvl[k-1].i_q;
         assign p_d = g_lvl[k-1].p_q;
      end

      argmin_level #(
         .N_IN     (NI),
         .METRIC_W (METRIC_W),
         .IDX_W    (L),
         .PATH_W   (PATH_W)
      ) u_level (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (in_ready),
         .valid_in   (vld[k]),
         .metric_in  (m_d),
         .idx_in     (i_d),
         .path_in    (p_d),
         .valid_out  (vld[k+1]),
         .metric_out (m_q),
         .idx_out    (i_q),
         .path_out   (p_q)
      );
   end

   assign out_valid  = vld[L];
   assign out_path   = g_lvl[L-1].p_q;
   assign out_state  = g_lvl[L-1].i_q;
   assign out_metric = g_lvl[L-1].m_q;
   // Pure function of the registered metric, so it is as stable as the data.
   assign norm_req   = out_valid && ({1'b0, out_metric} >= THRESH_X);

   // Beat index of whatever is loaded this cycle: if the current beat leaves
   // at the same edge, the newcomer is already the following beat.
   always_comb begin
      beat_next = beat_cnt;
      if (xfer)
         beat_next = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         renew     <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         beat_cnt <= beat_next;
         if (xfer)
            renew <= ~renew;
         if (in_ready && vld[L-1])
            frame_end <= (beat_next == LAST_BEAT);
      end
   end

endmodule

// File: tb/tb_path_metric_argmin.sv
// -----------------------------------------------------------------------------
// tb_path_metric_argmin
// Two instances: A (4 states, 4-bit metrics, frames of 3) for the directed
// cases, B (16 states, 6-bit metrics, frames of 8) for the random run.
// Expected results are pushed on input transfer; per-instance monitors pop
// and compare whenever the DUT presents a result.
// -----------------------------------------------------------------------------
module tb_path_metric_argmin;

   localparam int A_N = 4,  A_MW = 4, A_PW = 8, A_FL = 3, A_L = 2, A_TH = 8;
   localparam int B_N = 16, B_MW = 6, B_PW = 8, B_FL = 8, B_L = 4, B_TH = 32;
   localparam int A_EW = A_PW + 2 + A_MW + 1;
   localparam int B_EW = B_PW + 4 + B_MW + 1;

   logic clk;
   logic rst_n_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic norm_a, frame_end_a, renew_a;
   logic [A_N*A_MW-1:0] metric_a;
   logic [A_N*A_PW-1:0] path_a;
   logic [A_PW-1:0]     out_path_a;
   logic [1:0]          out_state_a;
   logic [A_MW-1:0]     out_metric_a;

   logic rst_n_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic norm_b, frame_end_b, renew_b;
   logic [B_N*B_MW-1:0] metric_b;
   logic [B_N*B_PW-1:0] path_b;
   logic [B_PW-1:0]     out_path_b;
   logic [3:0]          out_state_b;
   logic [B_MW-1:0]     out_metric_b;

   int checks = 0;
   int errors = 0;
   logic [A_EW-1:0] exp_q_a[$];
   logic [B_EW-1:0] exp_q_b[$];
   int beats_a = 0;
   int beats_b = 0;

   path_metric_argmin #(.NUM_STATES(A_N), .METRIC_W(A_MW), .PATH_W(A_PW),
                        .NORM_THRESH(A_TH), .FRAME_LEN(A_FL)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .metric_in(metric_a), .path_in(path_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_path(out_path_a), .out_state(out_state_a),
      .out_metric(out_metric_a), .norm_req(norm_a), .frame_end(frame_end_a),
      .renew(renew_a));

   path_metric_argmin #(.NUM_STATES(B_N), .METRIC_W(B_MW), .PATH_W(B_PW),
                        .NORM_THRESH(B_TH), .FRAME_LEN(B_FL)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .metric_in(metric_b), .path_in(path_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_path(out_path_b), .out_state(out_state_b),
      .out_metric(out_metric_b), .norm_req(norm_b), .frame_end(frame_end_b),
      .renew(renew_b));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: first state holding the smallest metric.
   function automatic int argmin_ref(input int m[16], input int n);
      int best = 0;
      for (int s = 1; s < n; s++)
         if (m[s] < m[best]) best = s;
      return best;
   endfunction

   task automatic vec4(input int a, input int b, input int c, input int d, output int m[16]);
      for (int s = 0; s < 16; s++) m[s] = 0;
      m[0] = a; m[1] = b; m[2] = c; m[3] = d;
   endtask

   // ---------------- drivers ----------------
   // Inputs change on the falling edge; the transfer decision is taken 2ns
   // later, once in_ready has settled, and counts for the next rising edge.
   task automatic drive_a(input bit v, input int m[16], input int p[16],
                          input bit rdy, output bit taken);
      int best;
      @(negedge clk);
      in_valid_a = v;
      for (int s = 0; s < A_N; s++) begin
         metric_a[s*A_MW +: A_MW] = m[s][A_MW-1:0];
         path_a[s*A_PW +: A_PW]   = p[s][A_PW-1:0];
      end
      out_ready_a = rdy;
      #2;
      taken = v && in_ready_a && rst_n_a;
      if (taken) begin
         best = argmin_ref(m, A_N);
         exp_q_a.push_back({p[best][A_PW-1:0], best[1:0], m[best][A_MW-1:0], 1'(m[best] >= A_TH)});
      end
   endtask

   task automatic drive_b(input bit v, input int m[16], input int p[16],
                          input bit rdy, output bit taken);
      int best;
      @(negedge clk);
      in_valid_b = v;
      for (int s = 0; s < B_N; s++) begin
         metric_b[s*B_MW +: B_MW] = m[s][B_MW-1:0];
         path_b[s*B_PW +: B_PW]   = p[s][B_PW-1:0];
      end
      out_ready_b = rdy;
      #2;
      taken = v && in_ready_b && rst_n_b;
      if (taken) begin
         best = argmin_ref(m, B_N);
         exp_q_b.push_back({p[best][B_PW-1:0], best[3:0], m[best][B_MW-1:0], 1'(m[best] >= B_TH)});
      end
   endtask

   task automatic send_a(input int m[16], input int p[16]);
      bit t;
      int guard = 0;
      do begin
         drive_a(1'b1, m, p, 1'b1, t);
         guard++;
      end while (!t && guard < 50);
      if (!t) check("send_a_timeout", 0, 1);
   endtask

   task automatic idle_a(input int n);
      int z[16];
      bit t;
      for (int s = 0; s < 16; s++) z[s] = 0;
      for (int i = 0; i < n; i++) drive_a(1'b0, z, z, 1'b1, t);
   endtask

   task automatic idle_b(input int n);
      int z[16];
      bit t;
      for (int s = 0; s < 16; s++) z[s] = 0;
      for (int i = 0; i < n; i++) drive_b(1'b0, z, z, 1'b1, t);
   endtask

   // Reset with out_ready low so in_ready can only be 1 through reset itself.
   task automatic reset_a();
      @(negedge clk);
      rst_n_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
      exp_q_a.delete();
      beats_a = 0;
      #2;
      check("a_in_ready_in_reset", in_ready_a, 1);
      @(negedge clk);
      #1;
      check("a_rst_out_valid", out_valid_a, 0);
      check("a_rst_out_path", out_path_a, 0);
      check("a_rst_out_state", out_state_a, 0);
      check("a_rst_out_metric", out_metric_a, 0);
      check("a_rst_norm", norm_a, 0);
      check("a_rst_frame_end", frame_end_a, 0);
      check("a_rst_renew", renew_a, 0);
      rst_n_a = 1'b1;
      out_ready_a = 1'b1;
   endtask

   task automatic reset_b();
      @(negedge clk);
      rst_n_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
      exp_q_b.delete();
      beats_b = 0;
      @(negedge clk);
      #1;
      check("b_rst_out_valid", out_valid_b, 0);
      check("b_rst_renew", renew_b, 0);
      rst_n_b = 1'b1;
   endtask

   // Counts cycles from the vector's presentation until out_valid rises.
   task automatic latency_a(input string name, input int m[16], input int p[16]);
      int z[16];
      bit t;
      int first = -1;
      for (int s = 0; s < 16; s++) z[s] = 0;
      send_a(m, p);
      for (int k = 1; k <= 12 && first < 0; k++) begin
         drive_a(1'b0, z, z, 1'b1, t);
         if (out_valid_a) first = k;
      end
      check(name, first, A_L);
   endtask

   // ---------------- monitors / scoreboard ----------------
   always begin
      logic [A_EW-1:0] e;
      @(negedge clk);
      #2;
      if (rst_n_a) begin
         check("a_in_ready", in_ready_a, !(out_valid_a && !out_ready_a));
         if (out_valid_a) begin
            if (exp_q_a.size() == 0) begin
               check("a_unexpected_output", 1, 0);
            end else begin
               e = exp_q_a[0];
               check("a_path", out_path_a, e[A_EW-1 -: A_PW]);
               check("a_state", out_state_a, e[A_MW+2 -: 2]);
               check("a_metric", out_metric_a, e[A_MW:1]);
               check("a_norm", norm_a, e[0]);
               check("a_frame_end", frame_end_a, (beats_a % A_FL) == A_FL - 1);
               check("a_renew", renew_a, beats_a % 2);
               if (out_ready_a) begin
                  void'(exp_q_a.pop_front());
                  beats_a++;
               end
            end
         end
      end
   end

   always begin
      logic [B_EW-1:0] e;
      @(negedge clk);
      #2;
      if (rst_n_b) begin
         check("b_in_ready", in_ready_b, !(out_valid_b && !out_ready_b));
         if (out_valid_b) begin
            if (exp_q_b.size() == 0) begin
               check("b_unexpected_output", 1, 0);
            end else begin
               e = exp_q_b[0];
               check("b_path", out_path_b, e[B_EW-1 -: B_PW]);
               check("b_state", out_state_b, e[B_MW+4 -: 4]);
               check("b_metric", out_metric_b, e[B_MW:1]);
               check("b_norm", norm_b, e[0]);
               check("b_frame_end", frame_end_b, (beats_b % B_FL) == B_FL - 1);
               check("b_renew", renew_b, beats_b % 2);
               if (out_ready_b) begin
                  void'(exp_q_b.pop_front());
                  beats_b++;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int m[16];
      int p[16];
      bit t;
      int sent;
      int cyc;
      rst_n_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; metric_a = '0; path_a = '0;
      rst_n_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; metric_b = '0; path_b = '0;

      // ---- A: directed ----
      reset_a();
      vec4(5, 3, 7, 9, m);
      vec4('hA1, 'hB2, 'hC3, 'hD4, p);
      latency_a("a_latency", m, p);
      vec4(6, 6, 6, 6, m);     send_a(m, p);
      vec4(9, 2, 2, 2, m);     send_a(m, p);
      vec4(8, 9, 10, 11, m);   send_a(m, p);
      vec4(12, 7, 15, 9, m);   send_a(m, p);
      vec4(15, 15, 15, 0, m);  send_a(m, p);
      idle_a(6);
      check("a_drain_directed", exp_q_a.size(), 0);

      // Backpressure: 6 distinct vectors, consumer stalls 3 cycles mid-stream.
      sent = 0;
      cyc  = 0;
      while (sent < 6 && cyc < 100) begin
         for (int s = 0; s < 16; s++) begin
            m[s] = $urandom_range(0, 15);
            p[s] = sent * 16 + s;
         end
         drive_a(1'b1, m, p, !(cyc >= 2 && cyc < 5), t);
         if (t) sent++;
         cyc++;
      end
      check("a_bp_sent", sent, 6);
      idle_a(6);
      check("a_drain_bp", exp_q_a.size(), 0);

      // Random traffic with random consumer stalls.
      for (int i = 0; i < 150; i++) begin
         for (int s = 0; s < 16; s++) begin
            m[s] = $urandom_range(0, 15);
            p[s] = $urandom_range(0, 255);
         end
         drive_a($urandom_range(0, 3) != 0, m, p, $urandom_range(0, 2) != 0, t);
      end
      idle_a(6);
      check("a_drain_random", exp_q_a.size(), 0);

      // Frame marking: 7 back-to-back transfers after a fresh reset.
      reset_a();
      for (int i = 0; i < 7; i++) begin
         vec4(i + 1, 15 - i, i + 3, 14, m);
         vec4(i, i + 16, i + 32, i + 48, p);
         send_a(m, p);
      end
      idle_a(5);
      check("a_frame_drain", exp_q_a.size(), 0);
      check("a_renew_after_7", renew_a, 1);

      // Reset with two vectors in flight.
      vec4(1, 2, 3, 4, m);
      vec4(17, 18, 19, 20, p);
      send_a(m, p);
      send_a(m, p);
      reset_a();
      vec4(4, 4, 2, 2, m);
      vec4('h11, 'h22, 'h33, 'h44, p);
      latency_a("a_latency_after_reset", m, p);
      idle_a(4);
      check("a_drain_after_reset", exp_q_a.size(), 0);

      // ---- B: 16 states, random against the reference ----
      reset_b();
      for (int s = 0; s < 16; s++) begin
         m[s] = 40 + s;
         p[s] = s;
      end
      m[13] = 5;
      begin
         int first;
         int z[16];
         first = -1;
         for (int s = 0; s < 16; s++) z[s] = 0;
         drive_b(1'b1, m, p, 1'b1, t);
         check("b_first_taken", t, 1);
         for (int k = 1; k <= 12 && first < 0; k++) begin
            drive_b(1'b0, z, z, 1'b1, t);
            if (out_valid_b) first = k;
         end
         check("b_latency", first, B_L);
      end
      idle_b(3);

      sent = 0;
      cyc  = 0;
      t    = 1'b1;
      while (sent < 1000 && cyc < 20000) begin
         bit v;
         if (t || !in_valid_b) begin
            int hi;
            hi = ($urandom_range(0, 1) != 0) ? 63 : 3;
            for (int s = 0; s < 16; s++) begin
               m[s] = $urandom_range(0, hi);
               p[s] = $urandom_range(0, 255);
            end
            v = ($urandom_range(0, 9) != 0);
         end else begin
            v = 1'b1;
         end
         drive_b(v, m, p, $urandom_range(0, 3) != 0, t);
         if (t) sent++;
         cyc++;
      end
      check("b_sent", sent, 1000);
      idle_b(8);
      check("b_drain", exp_q_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
